mux_channel_scanner: RTL

Sequencer that sits directly upstream of the 4:1 behavioral mux (inputs a/b/c/d, selects s1/s2, output y). It drives the two select lines through all four channels, holds each channel for a programmable dwell time, and captures the mux output y per channel. It presents each completed sweep as a 4-bit sample word with a one-cycle valid strobe. Sweeps run once per start request or back-to-back in continuous mode.

---
 rtl/mux_pkg.sv | 32 +++
 rtl/dwell_counter.sv | 31 +++
 rtl/mux_channel_scanner.sv | 113 +++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the 4:1 mux channel scanner and the mux benches.
package mux_pkg;

    // Scanner sequencing states.
    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Channel indices: a, b, c, d in select order.
    localparam logic [1:0] CH_A = 2'd0;
    localparam logic [1:0] CH_B = 2'd1;
    localparam logic [1:0] CH_C = 2'd2;
    localparam logic [1:0] CH_D = 2'd3;

    localparam int NUM_CH = 4;

    // Select lines as seen by the mux: s2 is the MSB, s1 the LSB.
    typedef struct packed {
        logic s2;
        logic s1;
    } sel_t;

    // Channel index to select-line mapping.
    function automatic sel_t ch_to_sel(input logic [1:0] ch);
        sel_t sel;
        sel.s1 = ch[0];
        sel.s2 = ch[1];
        return sel;
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// Counts the cycles a channel stays selected; terminal marks the last one.
module dwell_counter
    import mux_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] count;

    // With DWELL=1 the count never leaves 0 and terminal is high every cycle.
    assign terminal = (count == LAST);

    // Free-run while enabled, wrap to 0 after the last dwell cycle.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= terminal ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/mux_channel_scanner.sv
// Steps the 4:1 mux selects through a, b, c, d, holding each for DWELL
// cycles, and publishes the captured y values as one 4-bit sample per sweep.
module mux_channel_scanner
    import mux_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             continuous,
    input  logic             y,
    output logic             s1,
    output logic             s2,
    output logic             busy,
    output logic [3:0]       sample,
    output logic             valid,
    output logic [CNT_W-1:0] sweep_count
);

    state_t     state;
    state_t     next_state;
    logic [1:0] ch;
    logic [2:0] shadow;
    logic       terminal;
    logic       step;
    logic       sweep_done;
    logic       in_idle;
    logic       in_scan;
    sel_t       sel;

    assign in_idle    = (state == IDLE);
    assign in_scan    = (state == SCAN);
    // Last dwell cycle of the current channel: y is captured on this edge.
    assign step       = in_scan && terminal;
    assign sweep_done = step && (ch == CH_D);

    dwell_counter #(
        .DWELL (DWELL),
        .CNT_W (CNT_W)
    ) u_dwell (
        .clk      (clk),
        .rst      (rst),
        .clear    (in_idle),
        .enable   (in_scan),
        .terminal (terminal)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: start only counts in IDLE; continuous is only looked at
    // on the edge that closes a sweep.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = SCAN;
            SCAN: if (sweep_done && !continuous) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Channel index: advances after each dwell, wraps d -> a at sweep end.
    always_ff @(posedge clk) begin
        if (rst || in_idle) begin
            ch <= CH_A;
        end else if (step) begin
            ch <= ch + 2'd1;
        end
    end

    // Shadow capture of channels a..c; d goes straight into sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
        end else if (step) begin
            case (ch)
                CH_A:    shadow[0] <= y;
                CH_B:    shadow[1] <= y;
                CH_C:    shadow[2] <= y;
                default: shadow    <= shadow;
            endcase
        end
    end

    // Sample, strobe and sweep counter change only on a completed sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample      <= '0;
            valid       <= 1'b0;
            sweep_count <= '0;
        end else begin
            valid <= sweep_done;
            if (sweep_done) begin
                sample      <= {y, shadow};
                sweep_count <= sweep_count + 1'b1;
            end
        end
    end

    assign sel  = ch_to_sel(ch);
    assign s1   = sel.s1;
    assign s2   = sel.s2;
    assign busy = in_scan;

endmodule
